// File: rtl/shift_fu_pkg.sv
// Shared definitions for the shift functional unit.
//   shift_op_e : operation encoding carried in operand[2:0]
//   FLAG_*     : bit positions of Z, C and N inside the 8-bit flags word
package shift_fu_pkg;

  typedef enum logic [2:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_SRA = 3'd2,
    OP_ROL = 3'd3,
    OP_ROR = 3'd4
  } shift_op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

endpackage

// File: rtl/shift_fu_outq.sv
// Output queue of the shift unit: a DEPTH-entry FIFO whose head entry is
// offered to both the CDB and the ROB. Each entry remembers which of the two
// consumers has already taken it; the head leaves once both have.
//
// Handshake: a request (cdb_req_o / rob_req_o) is high while the head is valid
// and that consumer has not yet taken it. A grant only counts in a cycle where
// the matching request is high; grants without a request are ignored. The
// head pops at the edge where both done bits are set or being set.
//
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   push_i          issue valid; dropped when busy_o is high
//   push_data_i     packed entry payload
//   push_nowb_i     entry has no register writeback (never requests the CDB)
//   cdb_grant_i     CDB grant for the head entry
//   rob_grant_i     ROB grant for the head entry
//   cdb_req_o       CDB request for the head entry
//   rob_req_o       ROB request for the head entry
//   head_data_o     head payload, zero when empty
//   busy_o          queue full (registered)
module shift_fu_outq #(
  parameter int DEPTH = 2,
  parameter int EW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [EW-1:0] push_data_i,
  input  logic          push_nowb_i,
  input  logic          cdb_grant_i,
  input  logic          rob_grant_i,
  output logic          cdb_req_o,
  output logic          rob_req_o,
  output logic [EW-1:0] head_data_o,
  output logic          busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] cdb_done_q, cdb_done_d;
  logic [DEPTH-1:0] rob_done_q, rob_done_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;

  logic head_valid;
  logic cdb_fire;
  logic rob_fire;
  logic push;
  logic pop;

  always_comb begin
    head_valid = (count_q != '0);
    cdb_req_o  = head_valid & ~cdb_done_q[head_q];
    rob_req_o  = head_valid & ~rob_done_q[head_q];
    cdb_fire   = cdb_req_o & cdb_grant_i;
    rob_fire   = rob_req_o & rob_grant_i;
    pop        = head_valid
               & (cdb_done_q[head_q] | cdb_fire)
               & (rob_done_q[head_q] | rob_fire);
    // Full is judged on the registered count, so a pop in the same cycle
    // does not make room for an issue.
    push       = push_i & ~busy_q;

    count_d = count_q + CW'(push) - CW'(pop);
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push);
    busy_d  = (count_d == CW'(DEPTH));

    cdb_done_d = cdb_done_q;
    rob_done_d = rob_done_q;
    if (cdb_fire) cdb_done_d[head_q] = 1'b1;
    if (rob_fire) rob_done_d[head_q] = 1'b1;
    // A push never targets the head slot while it is still occupied, so the
    // initial done bits can simply overwrite the tail slot.
    if (push) begin
      cdb_done_d[tail_q] = push_nowb_i;
      rob_done_d[tail_q] = 1'b0;
    end

    head_data_o = head_valid ? mem_q[head_q] : '0;
    busy_o      = busy_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_done_q <= '0;
      rob_done_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      cdb_done_q <= cdb_done_d;
      rob_done_q <= rob_done_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
    end
  end

  // Payload storage needs no reset: it is masked by head_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= push_data_i;
  end

endmodule

// File: rtl/shift_fu_gen.sv
// Shift functional unit: computes SLL/SRL/SRA/ROL/ROR on issue, derives the
// N/C/Z flags, and parks the result in an output queue that is drained by
// independent CDB and ROB grants.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   input_transmit           issue valid (accepted when busy=0)
//   operand[2:0]             operation select, upper bits ignored
//   depvals[0], depvals[1]   value to shift, shift amount
//   wbs, flags, robid        destination reg (0 = none), incoming flags, tag
//   cdb_transmit             CDB grant;  cdb_transmit_out, cdb_id, cdb_val
//   rob_transmit             ROB grant;  rob_transmit_out, robid_out,
//                            flags_out, wbs_out, value_out
//   busy                     output queue full
module shift_fu_gen
  import shift_fu_pkg::*;
#(
  parameter int XLEN  = 8,
  parameter int ROBW  = 4,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 input_transmit,
  input  logic [7:0]           operand,
  input  logic [1:0][XLEN-1:0] depvals,
  input  logic [7:0]           wbs,
  input  logic [7:0]           flags,
  input  logic [ROBW-1:0]      robid,
  input  logic                 cdb_transmit,
  output logic                 cdb_transmit_out,
  output logic [ROBW-1:0]      cdb_id,
  output logic [XLEN-1:0]      cdb_val,
  input  logic                 rob_transmit,
  output logic                 rob_transmit_out,
  output logic [ROBW-1:0]      robid_out,
  output logic [7:0]           flags_out,
  output logic [7:0]           wbs_out,
  output logic [XLEN-1:0]      value_out,
  output logic                 busy
);

  localparam int SHW = $clog2(XLEN);
  localparam int EW  = ROBW + 8 + 8 + XLEN;

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [SHW-1:0]  rot_amt;
  logic [XLEN:0]   sll_w;
  logic [XLEN:0]   srl_w;
  logic [XLEN:0]   sra_w;
  logic [XLEN-1:0] rol_r;
  logic [XLEN-1:0] ror_r;
  logic [XLEN-1:0] res;
  logic            carry;
  logic [7:0]      flags_calc;
  logic [EW-1:0]   entry;
  logic [EW-1:0]   head;
  logic [4:0]      unused_operand_bits;

  assign a                   = depvals[0];
  assign b                   = depvals[1];
  assign rot_amt             = b[SHW-1:0];
  assign unused_operand_bits = operand[7:3];

  // Each shift is done one bit wider than XLEN so the extra bit catches the
  // last bit shifted out. Shifting by the full b value makes oversize
  // amounts fall out naturally: zeros for SLL/SRL, sign copies for SRA.
  always_comb begin
    sll_w = {1'b0, a} << b;
    srl_w = {a, 1'b0} >> b;
    sra_w = $unsigned($signed({a, 1'b0}) >>> b);
    rol_r = (a << rot_amt) | (a >> (XLEN - int'(rot_amt)));
    ror_r = (a >> rot_amt) | (a << (XLEN - int'(rot_amt)));

    res   = a;
    carry = 1'b0;
    case (operand[2:0])
      OP_SLL: begin res = sll_w[XLEN-1:0]; carry = sll_w[XLEN]; end
      OP_SRL: begin res = srl_w[XLEN:1];   carry = srl_w[0];    end
      OP_SRA: begin res = sra_w[XLEN:1];   carry = sra_w[0];    end
      OP_ROL: begin res = rol_r; carry = (rot_amt != '0) & rol_r[0];      end
      OP_ROR: begin res = ror_r; carry = (rot_amt != '0) & ror_r[XLEN-1]; end
      default: begin res = a; carry = 1'b0; end
    endcase

    flags_calc         = flags;
    flags_calc[FLAG_Z] = (res == '0);
    flags_calc[FLAG_C] = carry;
    flags_calc[FLAG_N] = res[XLEN-1];

    entry = {robid, flags_calc, wbs, res};
  end

  shift_fu_outq #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_outq (
    .clk         (clk),
    .rst         (rst),
    .push_i      (input_transmit),
    .push_data_i (entry),
    .push_nowb_i (wbs == 8'd0),
    .cdb_grant_i (cdb_transmit),
    .rob_grant_i (rob_transmit),
    .cdb_req_o   (cdb_transmit_out),
    .rob_req_o   (rob_transmit_out),
    .head_data_o (head),
    .busy_o      (busy)
  );

  assign robid_out = head[EW-1 -: ROBW];
  assign flags_out = head[XLEN+15 -: 8];
  assign wbs_out   = head[XLEN+7 -: 8];
  assign value_out = head[XLEN-1:0];
  assign cdb_id    = robid_out;
  assign cdb_val   = value_out;

endmodule
